// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : shared types for the hazard/forwarding scoreboard
// Rev 1.0
// ============================================================================
package hazard_pkg;

  // Shadow records are sized for the widest supported register address;
  // narrower configurations are zero-extended on entry.
  localparam int MAX_REG_ADDR_W = 8;

  typedef logic [MAX_REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t src1;
    reg_addr_t src2;
    logic      src2_used;
    reg_addr_t dest;
    logic      reg_write;
    logic      mem_to_reg;
  } stage_ctl_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

endpackage
`default_nettype wire

// File: rtl/hazard_src_match.sv
`default_nettype none
// ============================================================================
// hazard_src_match : compares one source register against one shadow stage
// Rev 1.0
// ============================================================================
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  reg_addr_t src,
  input  logic      src_used,
  input  logic      entry_valid,
  input  logic      entry_reg_write,
  input  reg_addr_t entry_dest,
  output logic      match
);

  logic w_zero_block;

  assign w_zero_block = ZERO_REG && (entry_dest == '0);
  assign match = entry_valid && entry_reg_write && src_used &&
                 (entry_dest == src) && !w_zero_block;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard_unit : shadow-tracked hazard, flush and forwarding control
// Rev 1.0
// ============================================================================
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter bit ZERO_REG   = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_en,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src2_used,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic                  branch_taken,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic                  flush_if_id,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cycles
);

  stage_ctl_t       r_ex, r_mem, r_wb, w_id;
  reg_addr_t        w_id_src [2];
  logic             w_id_used [2];
  reg_addr_t        w_ex_src [2];
  logic             w_ex_used [2];
  logic [1:0]       w_id_ex_match, w_id_mem_match;
  logic [1:0]       w_ex_mem_match, w_ex_wb_match;
  logic             w_hazard;
  fwd_sel_t         w_fwd [2];
  logic [CNT_W-1:0] r_cnt;
  logic             w_unused;

  assign w_id = '{valid:      id_valid,
                  src1:       reg_addr_t'(id_src1),
                  src2:       reg_addr_t'(id_src2),
                  src2_used:  id_src2_used,
                  dest:       reg_addr_t'(id_dest),
                  reg_write:  id_reg_write,
                  mem_to_reg: id_mem_to_reg};

  assign w_id_src[0]  = w_id.src1;
  assign w_id_src[1]  = w_id.src2;
  assign w_id_used[0] = 1'b1;
  assign w_id_used[1] = w_id.src2_used;
  assign w_ex_src[0]  = r_ex.src1;
  assign w_ex_src[1]  = r_ex.src2;
  assign w_ex_used[0] = 1'b1;
  assign w_ex_used[1] = r_ex.src2_used;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      hazard_src_match #(.ZERO_REG(ZERO_REG)) u_id_ex (
        .src(w_id_src[gi]), .src_used(w_id_used[gi]),
        .entry_valid(r_ex.valid), .entry_reg_write(r_ex.reg_write),
        .entry_dest(r_ex.dest), .match(w_id_ex_match[gi]));
      hazard_src_match #(.ZERO_REG(ZERO_REG)) u_id_mem (
        .src(w_id_src[gi]), .src_used(w_id_used[gi]),
        .entry_valid(r_mem.valid), .entry_reg_write(r_mem.reg_write),
        .entry_dest(r_mem.dest), .match(w_id_mem_match[gi]));
      hazard_src_match #(.ZERO_REG(ZERO_REG)) u_ex_mem (
        .src(w_ex_src[gi]), .src_used(w_ex_used[gi]),
        .entry_valid(r_mem.valid), .entry_reg_write(r_mem.reg_write),
        .entry_dest(r_mem.dest), .match(w_ex_mem_match[gi]));
      hazard_src_match #(.ZERO_REG(ZERO_REG)) u_ex_wb (
        .src(w_ex_src[gi]), .src_used(w_ex_used[gi]),
        .entry_valid(r_wb.valid), .entry_reg_write(r_wb.reg_write),
        .entry_dest(r_wb.dest), .match(w_ex_wb_match[gi]));
    end
  endgenerate

  // Without forwarding a producer must reach WB (first-half-cycle RF write)
  // before its consumer may leave ID.
  always_comb begin
    w_hazard = 1'b0;
    if (FWD_EN)
      w_hazard = id_valid && (|w_id_ex_match) && r_ex.mem_to_reg;
    else
      w_hazard = id_valid && (|(w_id_ex_match | w_id_mem_match));
  end

  assign stall_if_id = w_hazard && !branch_taken;
  assign bubble_ex   = w_hazard || branch_taken;
  assign flush_if_id = branch_taken;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_fwd[i] = FWD_RF;
      if (FWD_EN && r_ex.valid) begin
        if (w_ex_mem_match[i] && !r_mem.mem_to_reg)
          w_fwd[i] = FWD_EXMEM;
        else if (w_ex_wb_match[i])
          w_fwd[i] = FWD_MEMWB;
      end
    end
  end

  assign fwd_a        = w_fwd[0];
  assign fwd_b        = w_fwd[1];
  assign stall_cycles = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
      r_cnt <= '0;
    end else if (pipe_en) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= (bubble_ex || !id_valid) ? '0 : w_id;
      if (stall_if_id && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // A load in MEM feeding EX is excluded by the load-use stall.
  a_no_load_fwd_from_mem: assert property (@(posedge clk) disable iff (rst)
    !(r_ex.valid && (|w_ex_mem_match) && r_mem.mem_to_reg));

  assign w_unused = ^{r_mem.src1, r_mem.src2, r_mem.src2_used,
                      r_wb.src1, r_wb.src2, r_wb.src2_used, r_wb.mem_to_reg};

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_scoreboard_unit : directed vectors on forwarding and stall-only units
// Rev 1.0
// ============================================================================
module tb_hazard_scoreboard_unit;

  typedef struct {
    logic       v;
    logic [4:0] s1, s2;
    logic       u2;
    logic [4:0] d;
    logic       rw, m2r;
  } ins_t;

  typedef struct {
    logic       rst;
    int         dut;
    logic       pe;
    ins_t       in;
    logic       br;
    logic       st, bu, fl;
    logic [1:0] fa, fb;
    int         cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pipe_en = 1'b1, id_valid = 1'b0, id_src2_used = 1'b0;
  logic id_reg_write = 1'b0, id_mem_to_reg = 1'b0, branch_taken = 1'b0;
  logic [4:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
  logic [1:0] st_o, bu_o, fl_o;
  logic [1:0] fa_o [2];
  logic [1:0] fb_o [2];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  int total = 0, bad = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  // dut 0: forwarding present; dut 1: stall-only with a 2-bit counter
  hazard_scoreboard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b1), .ZERO_REG(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .pipe_en(pipe_en), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .branch_taken(branch_taken), .stall_if_id(st_o[0]), .bubble_ex(bu_o[0]),
    .flush_if_id(fl_o[0]), .fwd_a(fa_o[0]), .fwd_b(fb_o[0]), .stall_cycles(cnt0));

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b0), .ZERO_REG(1'b1), .CNT_W(2)) u_nofwd (
    .clk(clk), .rst(rst), .pipe_en(pipe_en), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .branch_taken(branch_taken), .stall_if_id(st_o[1]), .bubble_ex(bu_o[1]),
    .flush_if_id(fl_o[1]), .fwd_a(fa_o[1]), .fwd_b(fb_o[1]), .stall_cycles(cnt1));

  function automatic ins_t LD(int d, int s1);
    ins_t r = '{v:1, s1:5'(s1), s2:0, u2:0, d:5'(d), rw:1, m2r:1};
    return r;
  endfunction
  function automatic ins_t ALU(int d, int s1, int s2);
    ins_t r = '{v:1, s1:5'(s1), s2:5'(s2), u2:1, d:5'(d), rw:1, m2r:0};
    return r;
  endfunction
  function automatic ins_t IMM(int d, int s1, int s2);
    ins_t r = '{v:1, s1:5'(s1), s2:5'(s2), u2:0, d:5'(d), rw:1, m2r:0};
    return r;
  endfunction
  function automatic ins_t NOP();
    ins_t r = '{v:0, s1:0, s2:0, u2:0, d:0, rw:0, m2r:0};
    return r;
  endfunction
  function automatic vec_t V(logic r, int dut, logic pe, ins_t in, logic br,
                             logic st, logic bu, logic fl, logic [1:0] fa,
                             logic [1:0] fb, int cnt);
    vec_t x = '{rst:r, dut:dut, pe:pe, in:in, br:br, st:st, bu:bu, fl:fl,
                fa:fa, fb:fb, cnt:cnt};
    return x;
  endfunction

  task automatic chk(string nm, int idx, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s [%0d] got=%0d exp=%0d", nm, idx, got, exp);
    end
  endtask

  task automatic drive(ins_t in, logic br, logic pe);
    id_valid = in.v; id_src1 = in.s1; id_src2 = in.s2; id_src2_used = in.u2;
    id_dest = in.d; id_reg_write = in.rw; id_mem_to_reg = in.m2r;
    branch_taken = br; pipe_en = pe;
  endtask

  task automatic chk_all(int idx, int dut, logic st, logic bu, logic fl,
                         logic [1:0] fa, logic [1:0] fb, int cnt);
    chk("stall_if_id", idx, int'(st_o[dut]), int'(st));
    chk("bubble_ex", idx, int'(bu_o[dut]), int'(bu));
    chk("flush_if_id", idx, int'(fl_o[dut]), int'(fl));
    chk("fwd_a", idx, int'(fa_o[dut]), int'(fa));
    chk("fwd_b", idx, int'(fb_o[dut]), int'(fb));
    chk("stall_cycles", idx, (dut == 0) ? int'(cnt0) : int'(cnt1), cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Load-use with forwarding: one stall, then MEM/WB forward
    vq.push_back(V(1,0,1,LD(5,1),0,    0,0,0,0,0,0));
    vq.push_back(V(0,0,1,ALU(6,5,1),0, 1,1,0,0,0,0));
    vq.push_back(V(0,0,1,ALU(6,5,1),0, 0,0,0,0,0,1));
    vq.push_back(V(0,0,1,NOP(),0,      0,0,0,2,0,1));
    // ALU back-to-back with forwarding: EX/MEM forward on both operands
    vq.push_back(V(1,0,1,ALU(3,1,2),0, 0,0,0,0,0,0));
    vq.push_back(V(0,0,1,ALU(4,3,3),0, 0,0,0,0,0,0));
    vq.push_back(V(0,0,1,NOP(),0,      0,0,0,1,1,0));
    // Stall-only unit: two stalls, forced RF selects, counter saturates at 3
    vq.push_back(V(1,1,1,ALU(3,1,2),0, 0,0,0,0,0,0));
    vq.push_back(V(0,1,1,ALU(4,3,3),0, 1,1,0,0,0,0));
    vq.push_back(V(0,1,1,ALU(4,3,3),0, 1,1,0,0,0,1));
    vq.push_back(V(0,1,1,ALU(4,3,3),0, 0,0,0,0,0,2));
    vq.push_back(V(0,1,1,NOP(),0,      0,0,0,0,0,2));
    vq.push_back(V(0,1,1,ALU(3,1,2),0, 0,0,0,0,0,2));
    vq.push_back(V(0,1,1,ALU(4,3,3),0, 1,1,0,0,0,2));
    vq.push_back(V(0,1,1,ALU(4,3,3),0, 1,1,0,0,0,3));
    vq.push_back(V(0,1,1,ALU(4,3,3),0, 0,0,0,0,0,3));
    // Register zero and unused immediate operand never hazard
    vq.push_back(V(1,0,1,LD(0,1),0,    0,0,0,0,0,0));
    vq.push_back(V(0,0,1,ALU(7,0,0),0, 0,0,0,0,0,0));
    vq.push_back(V(0,0,1,LD(5,1),0,    0,0,0,0,0,0));
    vq.push_back(V(0,0,1,IMM(8,1,5),0, 0,0,0,0,0,0));
    // Branch coincident with load-use: flush and bubble, no stall or count
    vq.push_back(V(1,0,1,LD(5,1),0,    0,0,0,0,0,0));
    vq.push_back(V(0,0,1,ALU(6,5,1),1, 0,1,1,0,0,0));
    vq.push_back(V(0,0,1,NOP(),0,      0,0,0,0,0,0));
    // Freeze during load-use: hazard persists, counter holds, one count on release
    vq.push_back(V(1,0,1,LD(5,1),0,    0,0,0,0,0,0));
    vq.push_back(V(0,0,0,ALU(6,5,1),0, 1,1,0,0,0,0));
    vq.push_back(V(0,0,0,ALU(6,5,1),0, 1,1,0,0,0,0));
    vq.push_back(V(0,0,0,ALU(6,5,1),0, 1,1,0,0,0,0));
    vq.push_back(V(0,0,1,ALU(6,5,1),0, 1,1,0,0,0,0));
    vq.push_back(V(0,0,1,ALU(6,5,1),0, 0,0,0,0,0,1));
    vq.push_back(V(0,0,1,NOP(),0,      0,0,0,2,0,1));

    drive(NOP(), 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all(-1, 0, 0,0,0,2'b00,2'b00,0);
    chk_all(-2, 1, 0,0,0,2'b00,2'b00,0);
    @(posedge clk); #1;

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) begin
        rst = 1'b1; #2; rst = 1'b0;
      end
      drive(vq[i].in, vq[i].br, vq[i].pe);
      @(negedge clk);
      chk_all(i, vq[i].dut, vq[i].st, vq[i].bu, vq[i].fl, vq[i].fa, vq[i].fb, vq[i].cnt);
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a stall on the stall-only unit
    rst = 1'b1; #2; rst = 1'b0;
    drive(ALU(3,1,2), 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(ALU(4,3,3), 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("mid_stall", 100, int'(st_o[1]), 1);
    chk("mid_cnt", 100, int'(cnt1), 1);
    #2 rst = 1'b1;
    #1;
    chk_all(101, 1, 0,0,0,2'b00,2'b00,0);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_stall", 102, int'(st_o[1]), 0);
    chk("post_rst_bubble", 102, int'(bu_o[1]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
